vdp_super_vram_scheduler: RTL and testbench

- Slot scheduler for the 32-bit VRAM (SDRAM) port in super-res/super-mid modes.
- Divides time into 4-clock slots aligned to the pixel phase.
- Grants each slot to one of: display fetch, SDRAM refresh, CPU port or command engine.
- Sits between the super-res pixel fetcher, the CPU VRAM port, the command engine and the SDRAM controller. Presents a single registered request per slot to the SDRAM controller.

---
 rtl/vdp_super_vram_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_vdp_super_vram_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_super_vram_scheduler.sv
// Super-res VRAM slot scheduler: time is cut into 4-clock slots, each granted to
// refresh, display fetch, CPU or command engine, with one registered SDRAM request per slot.
module vdp_super_vram_scheduler #(
  parameter int REFRESH_INTERVAL = 390,
  parameter int REFRESH_MAX      = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        phase_sync,
  input  logic        super_res_drawing,
  input  logic [16:0] disp_addr,
  output logic [31:0] disp_data,
  output logic        disp_valid,
  input  logic        cpu_req,
  input  logic [18:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        cmd_req,
  input  logic [16:0] cmd_addr,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_be,
  input  logic [31:0] cmd_wdata,
  output logic        cmd_ack,
  output logic [31:0] cmd_rdata,
  output logic [16:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_rd,
  output logic        mem_we,
  output logic        mem_refresh,
  input  logic [31:0] mem_rdata
);
  localparam int CW = $clog2(REFRESH_INTERVAL);
  localparam int PW = $clog2(REFRESH_MAX + 1);

  typedef enum logic [2:0] {OWN_IDLE, OWN_REF, OWN_DISP, OWN_CPU, OWN_CMD} owner_t;

  owner_t        r_owner, w_owner_next, w_grant;
  logic [1:0]    r_phase, w_phase_next;
  logic [PW-1:0] r_pending, w_pending_next;
  logic [CW-1:0] r_refcnt, w_refcnt_next;
  logic          r_rr_cmd, w_rr_cmd_next;
  logic [1:0]    r_lane, w_lane_next;
  logic          r_slot_we, w_slot_we_next;
  logic [16:0]   r_mem_addr, w_mem_addr_next;
  logic [31:0]   r_mem_wdata, w_mem_wdata_next;
  logic [3:0]    r_mem_be, w_mem_be_next;
  logic          r_mem_rd, w_mem_rd_next, r_mem_we, w_mem_we_next;
  logic          r_mem_refresh, w_mem_refresh_next;
  logic [31:0]   r_disp_data, w_disp_data_next, r_cmd_rdata, w_cmd_rdata_next;
  logic [7:0]    r_cpu_rdata, w_cpu_rdata_next;
  logic          r_disp_valid, w_disp_valid_next;
  logic          r_cpu_ack, w_cpu_ack_next, r_cmd_ack, w_cmd_ack_next;
  logic          w_slot_start, w_credit, w_ref_grant;

  // A phase_sync in the phase-0 cycle restarts the slot, so no grant is taken.
  assign w_slot_start = (r_phase == 2'd0) && !phase_sync;
  assign w_ref_grant  = w_slot_start && (w_grant == OWN_REF);

  always_comb begin
    w_grant = OWN_IDLE;
    if (r_pending == PW'(REFRESH_MAX))   w_grant = OWN_REF;
    else if (super_res_drawing)          w_grant = OWN_DISP;
    else if (r_pending != '0)            w_grant = OWN_REF;
    else if (cpu_req && cmd_req)         w_grant = r_rr_cmd ? OWN_CMD : OWN_CPU;
    else if (cpu_req)                    w_grant = OWN_CPU;
    else if (cmd_req)                    w_grant = OWN_CMD;
  end

  always_comb begin
    w_credit      = (r_refcnt == CW'(REFRESH_INTERVAL - 1));
    w_refcnt_next = w_credit ? '0 : r_refcnt + CW'(1);
    w_pending_next = r_pending;
    if (w_credit && !w_ref_grant && (r_pending != PW'(REFRESH_MAX)))
      w_pending_next = r_pending + PW'(1);
    else if (!w_credit && w_ref_grant)
      w_pending_next = r_pending - PW'(1);
  end

  always_comb begin
    w_phase_next       = phase_sync ? 2'd0 : r_phase + 2'd1;
    w_owner_next       = r_owner;
    w_rr_cmd_next      = r_rr_cmd;
    w_lane_next        = r_lane;
    w_slot_we_next     = r_slot_we;
    w_mem_addr_next    = r_mem_addr;
    w_mem_wdata_next   = r_mem_wdata;
    w_mem_be_next      = r_mem_be;
    w_mem_rd_next      = 1'b0;
    w_mem_we_next      = 1'b0;
    w_mem_refresh_next = 1'b0;
    w_disp_data_next   = r_disp_data;
    w_cpu_rdata_next   = r_cpu_rdata;
    w_cmd_rdata_next   = r_cmd_rdata;
    w_disp_valid_next  = 1'b0;
    w_cpu_ack_next     = 1'b0;
    w_cmd_ack_next     = 1'b0;
    if (w_slot_start) begin
      w_owner_next = w_grant;
      case (w_grant)
        OWN_REF: w_mem_refresh_next = 1'b1;
        OWN_DISP: begin
          w_mem_addr_next = disp_addr;
          w_mem_be_next   = 4'hF;
          w_slot_we_next  = 1'b0;
          w_mem_rd_next   = 1'b1;
        end
        OWN_CPU: begin
          w_mem_addr_next  = cpu_addr[18:2];
          w_mem_be_next    = cpu_we ? (4'b0001 << cpu_addr[1:0]) : 4'hF;
          w_mem_wdata_next = {4{cpu_wdata}};
          w_lane_next      = cpu_addr[1:0];
          w_slot_we_next   = cpu_we;
          w_mem_rd_next    = !cpu_we;
          w_mem_we_next    = cpu_we;
          w_rr_cmd_next    = 1'b1;
        end
        OWN_CMD: begin
          w_mem_addr_next  = cmd_addr;
          w_mem_be_next    = cmd_we ? cmd_be : 4'hF;
          w_mem_wdata_next = cmd_wdata;
          w_slot_we_next   = cmd_we;
          w_mem_rd_next    = !cmd_we;
          w_mem_we_next    = cmd_we;
          w_rr_cmd_next    = 1'b0;
        end
        default: ;
      endcase
    end
    // Read data lands in phase 2; a truncated slot delivers neither data nor ack.
    if ((r_phase == 2'd2) && !phase_sync) begin
      case (r_owner)
        OWN_DISP: begin
          w_disp_data_next  = mem_rdata;
          w_disp_valid_next = 1'b1;
        end
        OWN_CPU: begin
          if (!r_slot_we) w_cpu_rdata_next = mem_rdata[{r_lane, 3'b000} +: 8];
          w_cpu_ack_next = 1'b1;
        end
        OWN_CMD: begin
          if (!r_slot_we) w_cmd_rdata_next = mem_rdata;
          w_cmd_ack_next = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase       <= '0;
      r_owner       <= OWN_IDLE;
      r_pending     <= '0;
      r_refcnt      <= '0;
      r_rr_cmd      <= 1'b0;
      r_lane        <= '0;
      r_slot_we     <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_be      <= '0;
      r_mem_rd      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_refresh <= 1'b0;
      r_disp_data   <= '0;
      r_cpu_rdata   <= '0;
      r_cmd_rdata   <= '0;
      r_disp_valid  <= 1'b0;
      r_cpu_ack     <= 1'b0;
      r_cmd_ack     <= 1'b0;
    end else begin
      r_phase       <= w_phase_next;
      r_owner       <= w_owner_next;
      r_pending     <= w_pending_next;
      r_refcnt      <= w_refcnt_next;
      r_rr_cmd      <= w_rr_cmd_next;
      r_lane        <= w_lane_next;
      r_slot_we     <= w_slot_we_next;
      r_mem_addr    <= w_mem_addr_next;
      r_mem_wdata   <= w_mem_wdata_next;
      r_mem_be      <= w_mem_be_next;
      r_mem_rd      <= w_mem_rd_next;
      r_mem_we      <= w_mem_we_next;
      r_mem_refresh <= w_mem_refresh_next;
      r_disp_data   <= w_disp_data_next;
      r_cpu_rdata   <= w_cpu_rdata_next;
      r_cmd_rdata   <= w_cmd_rdata_next;
      r_disp_valid  <= w_disp_valid_next;
      r_cpu_ack     <= w_cpu_ack_next;
      r_cmd_ack     <= w_cmd_ack_next;
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_be      = r_mem_be;
  assign mem_rd      = r_mem_rd;
  assign mem_we      = r_mem_we;
  assign mem_refresh = r_mem_refresh;
  assign disp_data   = r_disp_data;
  assign disp_valid  = r_disp_valid;
  assign cpu_rdata   = r_cpu_rdata;
  assign cpu_ack     = r_cpu_ack;
  assign cmd_rdata   = r_cmd_rdata;
  assign cmd_ack     = r_cmd_ack;
endmodule

// File: tb/tb_vdp_super_vram_scheduler.sv
// Bench for the super-res VRAM slot scheduler: directed literal scenarios plus
// randomized traffic compared every cycle against a slot-level reference model.
module tb_vdp_super_vram_scheduler;
  localparam int RI   = 8;
  localparam int RMAX = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        phase_sync = 1'b0, super_res_drawing = 1'b0;
  logic [16:0] disp_addr = '0;
  logic [31:0] disp_data;
  logic        disp_valid;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [18:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0, cpu_rdata;
  logic        cpu_ack;
  logic        cmd_req = 1'b0, cmd_we = 1'b0;
  logic [16:0] cmd_addr = '0;
  logic [3:0]  cmd_be = '0;
  logic [31:0] cmd_wdata = '0, cmd_rdata;
  logic        cmd_ack;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_be;
  logic        mem_rd, mem_we, mem_refresh;

  always #5 clk = ~clk;

  vdp_super_vram_scheduler #(.REFRESH_INTERVAL(RI), .REFRESH_MAX(RMAX)) dut (
    .clk(clk), .reset(reset), .phase_sync(phase_sync), .super_res_drawing(super_res_drawing),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cmd_req(cmd_req), .cmd_addr(cmd_addr), .cmd_we(cmd_we), .cmd_be(cmd_be),
    .cmd_wdata(cmd_wdata), .cmd_ack(cmd_ack), .cmd_rdata(cmd_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rd(mem_rd),
    .mem_we(mem_we), .mem_refresh(mem_refresh), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: who owns each slot and what the SDRAM side must show.
  typedef enum int {K_IDLE, K_REF, K_DISP, K_CPU, K_CMD} kind_e;
  int          m_phase = 0, m_pending = 0, m_tick = 0, m_lane = 0;
  bit          m_ptr_cmd = 0, m_we = 0;
  kind_e       m_kind = K_IDLE;
  logic [16:0] e_addr = '0;
  logic [31:0] e_wdata = '0, e_disp = '0, e_cmdr = '0;
  logic [3:0]  e_be = '0;
  logic [7:0]  e_cpur = '0;
  logic        e_rd = 0, e_wr = 0, e_ref = 0, e_dv = 0, e_cack = 0, e_mack = 0;

  task automatic model_step();
    int    credit, refg;
    kind_e win;
    credit = (m_tick == RI - 1) ? 1 : 0;
    refg = 0;
    {e_rd, e_wr, e_ref, e_dv, e_cack, e_mack} = '0;
    cyc++;
    if (m_phase == 2 && !phase_sync) begin
      case (m_kind)
        K_DISP: begin e_disp = mem_rdata; e_dv = 1; end
        K_CPU:  begin if (!m_we) e_cpur = 8'(mem_rdata >> (8 * m_lane)); e_cack = 1; end
        K_CMD:  begin if (!m_we) e_cmdr = mem_rdata; e_mack = 1; end
        default: ;
      endcase
    end
    if (m_phase == 0 && !phase_sync) begin
      if (m_pending == RMAX)       win = K_REF;
      else if (super_res_drawing)  win = K_DISP;
      else if (m_pending > 0)      win = K_REF;
      else if (cpu_req && cmd_req) win = m_ptr_cmd ? K_CMD : K_CPU;
      else if (cpu_req)            win = K_CPU;
      else if (cmd_req)            win = K_CMD;
      else                         win = K_IDLE;
      m_kind = win;
      case (win)
        K_REF:  begin e_ref = 1; refg = 1; end
        K_DISP: begin m_we = 0; e_addr = disp_addr; e_be = 4'hF; e_rd = 1; end
        K_CPU: begin
          m_we = cpu_we; m_lane = int'(cpu_addr[1:0]);
          e_addr = cpu_addr[18:2];
          e_be = cpu_we ? 4'(1 << m_lane) : 4'hF;
          e_wdata = {4{cpu_wdata}};
          e_rd = !cpu_we; e_wr = cpu_we; m_ptr_cmd = 1;
        end
        K_CMD: begin
          m_we = cmd_we; e_addr = cmd_addr;
          e_be = cmd_we ? cmd_be : 4'hF;
          e_wdata = cmd_wdata;
          e_rd = !cmd_we; e_wr = cmd_we; m_ptr_cmd = 0;
        end
        default: ;
      endcase
    end
    m_pending = m_pending + credit - refg;
    if (m_pending > RMAX) m_pending = RMAX;
    m_tick  = (m_tick + 1) % RI;
    m_phase = phase_sync ? 0 : (m_phase + 1) % 4;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      cyc = 0; m_phase = 0; m_pending = 0; m_tick = 0; m_lane = 0;
      m_ptr_cmd = 0; m_we = 0; m_kind = K_IDLE;
      e_addr = '0; e_wdata = '0; e_be = '0; e_disp = '0; e_cmdr = '0; e_cpur = '0;
      {e_rd, e_wr, e_ref, e_dv, e_cack, e_mack} = '0;
    end else begin
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("mem_rd", mem_rd, e_rd);
      chk("mem_we", mem_we, e_wr);
      chk("mem_refresh", mem_refresh, e_ref);
      chk("disp_valid", disp_valid, e_dv);
      chk("cpu_ack", cpu_ack, e_cack);
      chk("cmd_ack", cmd_ack, e_mack);
      chk("disp_data", disp_data, e_disp);
      chk("cpu_rdata", cpu_rdata, e_cpur);
      chk("cmd_rdata", cmd_rdata, e_cmdr);
      if (m_phase >= 1 && (m_kind == K_DISP || m_kind == K_CPU || m_kind == K_CMD)) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_be", mem_be, e_be);
        if (m_we) chk("mem_wdata", mem_wdata, e_wdata);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    {cpu_req, cmd_req, cpu_we, cmd_we, phase_sync, super_res_drawing} = '0;
    cpu_addr = '0; cpu_wdata = '0; cmd_addr = '0; cmd_be = '0; cmd_wdata = '0;
    disp_addr = '0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // sel: 0 refresh, 1 rd, 2 we, 3 cpu_ack, 4 cmd_ack, 5 disp_valid
  task automatic wait_for(input int sel, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((sel == 0 && mem_refresh) || (sel == 1 && mem_rd) || (sel == 2 && mem_we) ||
          (sel == 3 && cpu_ack) || (sel == 4 && cmd_ack) || (sel == 5 && disp_valid)) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, who, draw_left;

    // Reset state and idle refresh cadence
    do_reset();
    chk("reset_mem_addr", mem_addr, 17'h0);
    chk("reset_mem_be", mem_be, 4'h0);
    chk("reset_strobes", {mem_rd, mem_we, mem_refresh, cpu_ack, cmd_ack, disp_valid}, 6'b0);
    chk("reset_disp_data", disp_data, 32'h0);
    wait_for(0, 40, at); chk("first_refresh_cycle", at, 9);
    wait_for(0, 20, at); chk("second_refresh_cycle", at, 17);

    // Display fetch, then refresh preemption once credits saturate
    do_reset();
    super_res_drawing = 1'b1; disp_addr = 17'h00010; mem_rdata = 32'hA1B2C3D4;
    wait_for(1, 8, at); chk("disp_rd_cycle", at, 1);
    chk("disp_mem_addr", mem_addr, 17'h00010);
    chk("disp_mem_be", mem_be, 4'hF);
    wait_for(5, 8, at); chk("disp_valid_cycle", at, 3);
    chk("disp_data_val", disp_data, 32'hA1B2C3D4);
    wait_for(0, 80, at); chk("preempt_refresh_cycle", at, 57);
    wait_for(1, 8, at); chk("display_resume_cycle", at, 61);
    super_res_drawing = 1'b0;

    // CPU byte write
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00006; cpu_wdata = 8'h5A;
    wait_for(2, 8, at); chk("cpu_we_cycle", at, 1);
    chk("cpu_wr_addr", mem_addr, 17'h00001);
    chk("cpu_wr_be", mem_be, 4'b0100);
    chk("cpu_wr_wdata", mem_wdata, 32'h5A5A5A5A);
    wait_for(3, 8, at); chk("cpu_wr_ack_cycle", at, 3);
    cpu_req = 1'b0;

    // Round-robin between CPU and command engine
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00100;
    cmd_req = 1'b1; cmd_we = 1'b0; cmd_addr = 17'h00200; cmd_be = 4'hF;
    for (int k = 0; k < 4; k++) begin
      who = 0;
      for (int i = 0; i < 20 && who == 0; i++) begin
        @(negedge clk);
        if (cpu_ack) who = 1;
        else if (cmd_ack) who = 2;
      end
      chk($sformatf("rr_grant%0d", k), who, (k % 2 == 0) ? 1 : 2);
      if (who == 1) cpu_req = 1'b0;
      else if (who == 2) cmd_req = 1'b0;
      @(negedge clk);
      cpu_req = 1'b1; cmd_req = 1'b1;
    end
    cpu_req = 1'b0; cmd_req = 1'b0;

    // phase_sync truncating a CPU read in phase 2
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00005; mem_rdata = 32'h11223344;
    wait_for(1, 8, at); chk("sync_first_rd_cycle", at, 1);
    @(negedge clk); phase_sync = 1'b1;
    @(negedge clk); phase_sync = 1'b0;
    chk("sync_no_ack", cpu_ack, 1'b0);
    wait_for(1, 8, at); chk("sync_regrant_rd_cycle", at, 4);
    wait_for(3, 8, at); chk("sync_ack_cycle", at, 6);
    chk("sync_cpu_rdata", cpu_rdata, 8'h33);
    cpu_req = 1'b0;

    // Randomized traffic against the model
    do_reset();
    draw_left = 20;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (cpu_ack) cpu_req = 1'b0;
      else if (!cpu_req && $urandom_range(0, 3) == 0) begin
        cpu_req = 1'b1; cpu_addr = 19'($urandom); cpu_we = 1'($urandom); cpu_wdata = 8'($urandom);
      end
      if (cmd_ack) cmd_req = 1'b0;
      else if (!cmd_req && $urandom_range(0, 3) == 0) begin
        cmd_req = 1'b1; cmd_addr = 17'($urandom); cmd_we = 1'($urandom);
        cmd_be = 4'($urandom); cmd_wdata = $urandom;
      end
      phase_sync = ($urandom_range(0, 23) == 0);
      mem_rdata = $urandom;
      disp_addr = 17'($urandom);
      if (draw_left == 0) begin
        super_res_drawing = !super_res_drawing;
        draw_left = $urandom_range(4, 150);
      end else begin
        draw_left--;
      end
    end
    phase_sync = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
